// File: rtl/dest_fetch_pkg.sv
// Shared field widths for the fragment triple and counter/index sizing helpers.
package dest_fetch_pkg;

    localparam int DF_PIXEL_WIDTH = 16;
    localparam int DF_ADDR_WIDTH  = 16;

    // Bits needed to hold a count from 0 to depth inclusive.
    function automatic int df_cnt_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    function automatic int df_idx_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/dest_fetch_fwft.sv
// First-word-fall-through FIFO; the head entry is visible whenever o_empty is low.
module fwft_fifo
    import dest_fetch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_push,
    input  logic [WIDTH-1:0]               i_data,
    input  logic                           i_pop,
    output logic [WIDTH-1:0]               o_data,
    output logic                           o_empty,
    output logic [df_cnt_width(DEPTH)-1:0] o_count
);

    localparam int CW = df_cnt_width(DEPTH);
    localparam int IW = df_idx_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [IW-1:0]    r_rd_ptr;
    logic [IW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && (r_count != CW'(DEPTH));
    assign w_do_pop  = i_pop && (r_count != '0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= (r_wr_ptr == IW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == IW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/dest_fetch.sv
// Destination-read stage: issues framebuffer reads, realigns returning data with
// the fragment, and stalls fragments whose address has an unretired write.
module dest_fetch
    import dest_fetch_pkg::*;
#(
    parameter int PIXEL_WIDTH  = DF_PIXEL_WIDTH,
    parameter int ADDR_WIDTH   = DF_ADDR_WIDTH,
    parameter int READ_LATENCY = 2,
    parameter int HAZARD_DEPTH = 4
) (
    input  logic                   aclk,
    input  logic                   reset,
    input  logic                   s_frag_valid,
    output logic                   s_frag_ready,
    input  logic [ADDR_WIDTH-1:0]  s_frag_addr,
    input  logic [PIXEL_WIDTH-1:0] s_frag_source,
    output logic                   fb_rd_en,
    output logic [ADDR_WIDTH-1:0]  fb_rd_addr,
    input  logic [PIXEL_WIDTH-1:0] fb_rd_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [ADDR_WIDTH-1:0]  m_addr,
    output logic [PIXEL_WIDTH-1:0] m_source,
    output logic [PIXEL_WIDTH-1:0] m_dest,
    input  logic                   wb_done
);

    localparam int OUT_DEPTH = READ_LATENCY + 2;
    localparam int OCW       = df_cnt_width(OUT_DEPTH);
    localparam int IFW       = df_cnt_width(READ_LATENCY);
    localparam int SW        = df_cnt_width(2 * OUT_DEPTH);
    localparam int HCW       = df_cnt_width(HAZARD_DEPTH);
    localparam int HIW       = df_idx_width(HAZARD_DEPTH);
    localparam int TW        = ADDR_WIDTH + 2 * PIXEL_WIDTH;

    logic [READ_LATENCY-1:0] r_sr_valid;
    logic [ADDR_WIDTH-1:0]   r_sr_addr [READ_LATENCY];
    logic [PIXEL_WIDTH-1:0]  r_sr_src  [READ_LATENCY];

    logic [ADDR_WIDTH-1:0]   r_haz_addr [HAZARD_DEPTH];
    logic [HAZARD_DEPTH-1:0] r_haz_vld;
    logic [HIW-1:0]          r_haz_wr;
    logic [HIW-1:0]          r_haz_rd;
    logic [HCW-1:0]          r_haz_count;

    logic [IFW-1:0] w_inflight;
    logic [OCW-1:0] w_out_count;
    logic [SW-1:0]  w_used;
    logic           w_addr_hit;
    logic           w_accept;
    logic           w_haz_pop;
    logic           w_tail_push;
    logic           w_out_empty;
    logic           w_out_pop;
    logic [TW-1:0]  w_head;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) w_inflight = w_inflight + IFW'(r_sr_valid[i]);
        w_addr_hit = 1'b0;
        for (int i = 0; i < HAZARD_DEPTH; i++) begin
            if (r_haz_vld[i] && (r_haz_addr[i] == s_frag_addr)) w_addr_hit = 1'b1;
        end
    end

    // Credits cover both the read pipe and the buffer, so a stalled output can never overflow.
    assign w_used       = SW'(w_inflight) + SW'(w_out_count);
    assign s_frag_ready = !reset && (w_used < SW'(OUT_DEPTH))
                          && (r_haz_count < HCW'(HAZARD_DEPTH)) && !w_addr_hit;
    assign w_accept     = s_frag_valid && s_frag_ready;
    assign fb_rd_en     = w_accept;
    assign fb_rd_addr   = s_frag_addr;
    assign w_haz_pop    = wb_done && (r_haz_count != '0);
    assign w_tail_push  = r_sr_valid[READ_LATENCY-1] && !reset;

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_sr_valid <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_sr_addr[i] <= '0;
                r_sr_src[i]  <= '0;
            end
        end else begin
            r_sr_valid[0] <= w_accept;
            r_sr_addr[0]  <= s_frag_addr;
            r_sr_src[0]   <= s_frag_source;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_sr_valid[i] <= r_sr_valid[i-1];
                r_sr_addr[i]  <= r_sr_addr[i-1];
                r_sr_src[i]   <= r_sr_src[i-1];
            end
        end
    end

    // Push and pop never target the same slot: that would need the table both empty and full.
    always_ff @(posedge aclk) begin
        if (reset) begin
            for (int i = 0; i < HAZARD_DEPTH; i++) r_haz_addr[i] <= '0;
            r_haz_vld   <= '0;
            r_haz_wr    <= '0;
            r_haz_rd    <= '0;
            r_haz_count <= '0;
        end else begin
            if (w_accept) begin
                r_haz_addr[r_haz_wr] <= s_frag_addr;
                r_haz_vld[r_haz_wr]  <= 1'b1;
                r_haz_wr <= (r_haz_wr == HIW'(HAZARD_DEPTH - 1)) ? '0 : r_haz_wr + 1'b1;
            end
            if (w_haz_pop) begin
                r_haz_vld[r_haz_rd] <= 1'b0;
                r_haz_rd <= (r_haz_rd == HIW'(HAZARD_DEPTH - 1)) ? '0 : r_haz_rd + 1'b1;
            end
            r_haz_count <= r_haz_count + HCW'(w_accept) - HCW'(w_haz_pop);
        end
    end

    assign w_out_pop = !w_out_empty && m_ready;

    fwft_fifo #(
        .WIDTH (TW),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .i_clk   (aclk),
        .i_reset (reset),
        .i_push  (w_tail_push),
        .i_data  ({r_sr_addr[READ_LATENCY-1], r_sr_src[READ_LATENCY-1], fb_rd_data}),
        .i_pop   (w_out_pop),
        .o_data  (w_head),
        .o_empty (w_out_empty),
        .o_count (w_out_count)
    );

    assign m_valid  = !w_out_empty;
    assign m_addr   = w_head[TW-1 -: ADDR_WIDTH];
    assign m_source = w_head[2*PIXEL_WIDTH-1 -: PIXEL_WIDTH];
    assign m_dest   = w_head[PIXEL_WIDTH-1:0];

endmodule

// File: doc/dest_fetch.md
Name: dest_fetch

Overview:
- Upstream neighbour of the logic-op stage: accepts fragments (address and source pixel) and issues destination reads to the framebuffer.
- Realigns the fixed-latency read data with the fragment and presents {addr, source, dest} to the logic-op stage.
- Blocks read-after-write hazards: a fragment whose address is still in flight, not yet written back, is stalled at the input.

Parameters:
- PIXEL_WIDTH, 16, pixel width in bits (matches logic-op stage).
- ADDR_WIDTH, 16, framebuffer word address width.
- READ_LATENCY, 2, fixed cycles from fb_rd_en to valid fb_rd_data (≥1).
- HAZARD_DEPTH, 4, maximum fragments issued but not yet retired by wb_done (≥1).
- Localparam OUT_DEPTH = READ_LATENCY + 2, output buffer entries.

Ports:
- aclk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_frag_valid  in  1  input fragment valid
- s_frag_ready  out  1  input fragment accepted when valid&ready
- s_frag_addr  in  ADDR_WIDTH  destination address
- s_frag_source  in  PIXEL_WIDTH  source pixel
- fb_rd_en  out  1  framebuffer read strobe
- fb_rd_addr  out  ADDR_WIDTH  framebuffer read address
- fb_rd_data  in  PIXEL_WIDTH  read data, valid READ_LATENCY cycles after fb_rd_en
- m_valid  out  1  output triple valid
- m_ready  in  1  downstream accepts (logic-op ce path)
- m_addr  out  ADDR_WIDTH  fragment address
- m_source  out  PIXEL_WIDTH  source pixel
- m_dest  out  PIXEL_WIDTH  destination pixel read from framebuffer
- wb_done  in  1  one pulse per retired write, in issue order

Behaviour:
- Issue condition (combinational):
  - s_frag_ready = !reset & (inflight + out_count < OUT_DEPTH) & (haz_count < HAZARD_DEPTH) & !addr_hit.
  - inflight counts reads in the latency pipe; out_count counts output buffer occupancy.
  - addr_hit = s_frag_addr equals any valid hazard-table entry.
  - All counts use pre-update values: a same-cycle pop or wb_done does not free space until the next cycle.
- On accept:
  - fb_rd_en=1 and fb_rd_addr=s_frag_addr in the same cycle (combinational).
  - {addr, source} enters a READ_LATENCY-deep shift register with a valid bit.
  - addr is pushed into the hazard table (in-order FIFO with parallel compare on all valid entries).
- At the shift-register tail, {addr, source, fb_rd_data} is pushed into the output FIFO.
  - Back-pressure cannot overflow the FIFO, guaranteed by the credit rule.
- Output FIFO is first-word-fall-through:
  - m_valid = !empty; m_* shows the head entry.
  - Pop on m_valid & m_ready.
  - Outputs hold stable while m_valid & !m_ready.
- wb_done pops the oldest hazard entry.
  - wb_done with an empty table is ignored (no underflow).
  - A matching entry retiring in the same cycle still blocks that cycle; the fragment is accepted next cycle.
- Same address twice back-to-back: the second fragment stalls until its predecessor is retired by wb_done.
- Ordering: outputs leave strictly in acceptance order; no reordering.
- Throughput: 1 fragment/cycle with distinct addresses, m_ready=1 and prompt wb_done.
- Reset, all values apply the cycle after reset is sampled high:
  - fb_rd_en=0, m_valid=0, s_frag_ready=0 while reset is high.
  - Shift register, output FIFO and hazard table are cleared; counters are 0.
  - m_addr/m_source/m_dest = 0.
- Reset mid-operation: in-flight reads are discarded, and fb_rd_data returning after reset is ignored. wb_done pulses for discarded fragments are ignored because the table is empty.

Decomposition:
- Shared package/include: the fragment triple field widths. No new opcodes; logic-op encodings are not used here.
- One natural sub-module: fwft_fifo (parameterised width/depth, count output), used for the output buffer.
- Hazard table stays in-module; it needs a parallel compare on every entry.

Test Plan:
- Reset: hold reset 3 cycles during traffic -> fb_rd_en=0, m_valid=0, s_frag_ready=0; first fragment after release issues next cycle.
- Streaming: addrs 0x10,0x11,0x12,0x13, m_ready=1, wb_done 2 cycles after each m accept, mem[a]=a^0xFFFF -> m_dest=0xFFEF,0xFFEE,0xFFED,0xFFEC in order, 1 per cycle.
- Hazard: addr 0x20 then 0x20, wb_done asserted 5 cycles after first m accept -> second accepted exactly 1 cycle after wb_done; its m_dest reflects post-write memory.
- Back-pressure: m_ready=0 for 20 cycles, continuous distinct fragments -> exactly OUT_DEPTH=4 accepted; m_* stable; on m_ready=1 all 4 drain in order and no data is lost.
- Table full: HAZARD_DEPTH=4 distinct addrs, no wb_done -> 5th stalls; single wb_done -> 5th accepted next cycle.
- Spurious wb_done with empty table -> no state change; later hazard on 0x30 still blocks correctly.
